// File: rtl/interrupt_sequencer.sv
// Interrupt entry sequencer: pushes PC and P for NMI/IRQ (or does dummy stack
// reads for reset), fetches the vector and reloads PC and SP.
module interrupt_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        enableFFs,
    input  logic        pendingInterrupt,
    input  logic        nmiGenerated,
    input  logic        irqGenerated,
    input  logic        resetDetected,
    input  logic        instructionBoundary,
    input  logic [15:0] pcIn,
    input  logic [7:0]  statusIn,
    input  logic [7:0]  spIn,
    input  logic [7:0]  dataIn,
    output logic [15:0] addrOut,
    output logic [7:0]  dataOut,
    output logic        readEn,
    output logic        writeEn,
    output logic        busy,
    output logic        interruptStarted,
    output logic        setIFlag,
    output logic        pcLoad,
    output logic [15:0] pcLoadValue,
    output logic        spLoad,
    output logic [7:0]  spLoadValue
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CAPTURE  = 3'd1,
        PUSH_PCH = 3'd2,
        PUSH_PCL = 3'd3,
        PUSH_P   = 3'd4,
        VEC_LO   = 3'd5,
        VEC_HI   = 3'd6
    } stateT;

    localparam logic [1:0] TYPE_IRQ   = 2'd0;
    localparam logic [1:0] TYPE_NMI   = 2'd1;
    localparam logic [1:0] TYPE_RESET = 2'd2;

    stateT       stateR;
    stateT       stateNextS;
    logic        startS;
    logic [1:0]  typeS;
    logic [1:0]  typeR;
    logic [15:0] pcR;
    logic [7:0]  statusR;
    logic [7:0]  spR;
    logic [7:0]  vecLoR;
    logic [15:0] baseS;

    // Status byte as it lands on the stack: bit5 reads as 1, B is cleared.
    function automatic logic [7:0] pushedStatus(input logic [7:0] p);
        return {p[7:6], 1'b1, 1'b0, p[3:0]};
    endfunction

    function automatic logic [15:0] vectorBase(input logic [1:0] t);
        case (t)
            TYPE_NMI:   return 16'hFFFA;
            TYPE_RESET: return 16'hFFFC;
            default:    return 16'hFFFE;
        endcase
    endfunction

    // Source priority: reset over NMI over IRQ.
    always_comb begin
        if (resetDetected) begin
            typeS = TYPE_RESET;
        end else if (nmiGenerated) begin
            typeS = TYPE_NMI;
        end else begin
            typeS = TYPE_IRQ;
        end
    end

    // Next-state logic; the sequence only advances on enabled cycles.
    always_comb begin
        stateNextS = stateR;
        startS     = 1'b0;
        if (enableFFs) begin
            case (stateR)
                IDLE: begin
                    if (instructionBoundary && pendingInterrupt &&
                        (nmiGenerated || irqGenerated || resetDetected)) begin
                        stateNextS = CAPTURE;
                        startS     = 1'b1;
                    end else begin
                        stateNextS = IDLE;
                    end
                end
                CAPTURE:  stateNextS = PUSH_PCH;
                PUSH_PCH: stateNextS = PUSH_PCL;
                PUSH_PCL: stateNextS = PUSH_P;
                PUSH_P:   stateNextS = VEC_LO;
                VEC_LO:   stateNextS = VEC_HI;
                VEC_HI:   stateNextS = IDLE;
                default:  stateNextS = IDLE;
            endcase
        end else begin
            stateNextS = stateR;
        end
    end

    // State register and context latches.
    always_ff @(posedge clk) begin
        if (rst) begin
            stateR  <= IDLE;
            typeR   <= 2'd0;
            pcR     <= 16'h0000;
            statusR <= 8'h00;
            spR     <= 8'h00;
            vecLoR  <= 8'h00;
        end else begin
            stateR <= stateNextS;
            if (startS) begin
                typeR   <= typeS;
                pcR     <= pcIn;
                statusR <= statusIn;
                spR     <= spIn;
            end
            if (enableFFs && (stateR == VEC_LO)) begin
                vecLoR <= dataIn;
            end
        end
    end

    assign baseS = vectorBase(typeR);

    // Moore output decode from the state register and latches.
    always_comb begin
        addrOut          = 16'h0000;
        dataOut          = 8'h00;
        readEn           = 1'b0;
        writeEn          = 1'b0;
        busy             = (stateR != IDLE);
        interruptStarted = 1'b0;
        setIFlag         = 1'b0;
        pcLoad           = 1'b0;
        pcLoadValue      = 16'h0000;
        spLoad           = 1'b0;
        spLoadValue      = 8'h00;
        case (stateR)
            PUSH_PCH: begin
                addrOut = {8'h01, spR};
                dataOut = pcR[15:8];
                writeEn = (typeR != TYPE_RESET);
                readEn  = (typeR == TYPE_RESET);
            end
            PUSH_PCL: begin
                addrOut = {8'h01, spR - 8'd1};
                dataOut = pcR[7:0];
                writeEn = (typeR != TYPE_RESET);
                readEn  = (typeR == TYPE_RESET);
            end
            PUSH_P: begin
                addrOut          = {8'h01, spR - 8'd2};
                dataOut          = pushedStatus(statusR);
                writeEn          = (typeR != TYPE_RESET);
                readEn           = (typeR == TYPE_RESET);
                interruptStarted = 1'b1;
                setIFlag         = 1'b1;
            end
            VEC_LO: begin
                addrOut = baseS;
                readEn  = 1'b1;
            end
            VEC_HI: begin
                addrOut     = baseS + 16'd1;
                readEn      = 1'b1;
                pcLoad      = 1'b1;
                pcLoadValue = {dataIn, vecLoR};
                spLoad      = 1'b1;
                spLoadValue = spR - 8'd3;
            end
            default: begin
                addrOut = 16'h0000;
            end
        endcase
    end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Randomized and directed bench for interrupt_sequencer against a step-indexed
// behavioural model, plus literal bus-trace expectations.
module tb_interrupt_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enableFFs = 1'b1;
    logic        pendingInterrupt = 1'b0;
    logic        nmiGenerated = 1'b0;
    logic        irqGenerated = 1'b0;
    logic        resetDetected = 1'b0;
    logic        instructionBoundary = 1'b0;
    logic [15:0] pcIn = 16'h0000;
    logic [7:0]  statusIn = 8'h00;
    logic [7:0]  spIn = 8'h00;
    logic [7:0]  dataIn;
    logic [7:0]  memSeed = 8'h5A;
    logic [15:0] addrOut;
    logic [7:0]  dataOut;
    logic        readEn, writeEn, busy, interruptStarted, setIFlag, pcLoad, spLoad;
    logic [15:0] pcLoadValue;
    logic [7:0]  spLoadValue;

    int checks = 0;
    int errors = 0;

    // model: step 0 idle, 1 capture, 2..4 pushes, 5 vector low, 6 vector high
    int          mStep = 0;
    int          mType = 0;   // 0 IRQ, 1 NMI, 2 reset
    logic [15:0] mPc = 16'h0000;
    logic [7:0]  mSt = 8'h00, mSp = 8'h00, mLo = 8'h00;

    logic [23:0] writeLog[$];
    logic [15:0] readLog[$];
    logic [15:0] pcLog;
    logic [7:0]  spLog;
    int          pcLoadCount, startCount, busyCount;

    always #5 clk = ~clk;

    function automatic logic [7:0] memByte(input logic [15:0] a, input logic [7:0] s);
        case (a)
            16'hFFFE: return 8'h00;
            16'hFFFF: return 8'h80;
            16'hFFFA: return s;
            16'hFFFB: return ~s;
            16'hFFFC: return s ^ 8'h55;
            16'hFFFD: return s ^ 8'hAA;
            default:  return a[7:0] ^ a[15:8] ^ s;
        endcase
    endfunction

    assign dataIn = memByte(addrOut, memSeed);

    interrupt_sequencer dut (
        .clk(clk), .rst(rst), .enableFFs(enableFFs),
        .pendingInterrupt(pendingInterrupt), .nmiGenerated(nmiGenerated),
        .irqGenerated(irqGenerated), .resetDetected(resetDetected),
        .instructionBoundary(instructionBoundary),
        .pcIn(pcIn), .statusIn(statusIn), .spIn(spIn), .dataIn(dataIn),
        .addrOut(addrOut), .dataOut(dataOut), .readEn(readEn), .writeEn(writeEn),
        .busy(busy), .interruptStarted(interruptStarted), .setIFlag(setIFlag),
        .pcLoad(pcLoad), .pcLoadValue(pcLoadValue), .spLoad(spLoad),
        .spLoadValue(spLoadValue)
    );

    function automatic logic [15:0] mBase();
        return (mType == 2) ? 16'hFFFC : (mType == 1) ? 16'hFFFA : 16'hFFFE;
    endfunction

    function automatic logic [54:0] modelExpect();
        logic [15:0] a = 16'h0000, plv = 16'h0000;
        logic [7:0]  d = 8'h00, slv = 8'h00, s;
        logic re = 1'b0, we = 1'b0, st = 1'b0, si = 1'b0, pl = 1'b0, sl = 1'b0;
        int j;
        if (mStep >= 2 && mStep <= 4) begin
            j = mStep - 2;
            s = mSp - 8'(j);
            a = {8'h01, s};
            d = (j == 0) ? mPc[15:8] : (j == 1) ? mPc[7:0] : ((mSt | 8'h20) & 8'hEF);
            we = (mType != 2);
            re = (mType == 2);
            st = (mStep == 4);
            si = (mStep == 4);
        end else if (mStep == 5) begin
            a = mBase();
            re = 1'b1;
        end else if (mStep == 6) begin
            a = mBase() + 16'd1;
            re = 1'b1;
            pl = 1'b1;
            plv = {memByte(a, memSeed), mLo};
            sl = 1'b1;
            slv = mSp - 8'd3;
        end
        return {a, d, re, we, (mStep != 0), st, si, pl, plv, sl, slv};
    endfunction

    task automatic modelUpdate();
        if (rst) begin
            mStep = 0; mType = 0; mPc = 16'h0000; mSt = 8'h00; mSp = 8'h00; mLo = 8'h00;
        end else if (enableFFs) begin
            if (mStep == 0) begin
                if (instructionBoundary && pendingInterrupt &&
                    (nmiGenerated || irqGenerated || resetDetected)) begin
                    mStep = 1;
                    mType = resetDetected ? 2 : nmiGenerated ? 1 : 0;
                    mPc = pcIn; mSt = statusIn; mSp = spIn;
                end
            end else if (mStep == 6) begin
                mStep = 0;
            end else begin
                if (mStep == 5) mLo = memByte(mBase(), memSeed);
                mStep = mStep + 1;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic compareAndLog();
        logic [54:0] act, exp;
        act = {addrOut, dataOut, readEn, writeEn, busy, interruptStarted, setIFlag,
               pcLoad, pcLoadValue, spLoad, spLoadValue};
        exp = modelExpect();
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL outputs t=%0t step=%0d: got %h expected %h", $time, mStep, act, exp);
        end
        if (writeEn === 1'b1) writeLog.push_back({addrOut, dataOut});
        if (readEn === 1'b1) readLog.push_back(addrOut);
        if (pcLoad === 1'b1) begin pcLog = pcLoadValue; pcLoadCount++; end
        if (spLoad === 1'b1) spLog = spLoadValue;
        if (interruptStarted === 1'b1) startCount++;
        if (busy === 1'b1) busyCount++;
    endtask

    task automatic tick();
        @(posedge clk);
        modelUpdate();
        @(negedge clk);
        compareAndLog();
    endtask

    task automatic clearLogs();
        writeLog.delete(); readLog.delete();
        pcLog = 16'h0000; spLog = 8'h00;
        pcLoadCount = 0; startCount = 0; busyCount = 0;
    endtask

    task automatic startReq(input logic n, input logic i, input logic r,
                            input logic [15:0] pc, input logic [7:0] st, input logic [7:0] sp);
        clearLogs();
        enableFFs = 1'b1; instructionBoundary = 1'b1; pendingInterrupt = 1'b1;
        nmiGenerated = n; irqGenerated = i; resetDetected = r;
        pcIn = pc; statusIn = st; spIn = sp;
        tick();
        // later input changes must be ignored by the running sequence
        pendingInterrupt = 1'b0;
        nmiGenerated = 1'($urandom_range(1)); irqGenerated = 1'($urandom_range(1));
        resetDetected = 1'($urandom_range(1));
        pcIn = 16'($urandom); statusIn = 8'($urandom); spIn = 8'($urandom);
    endtask

    logic [15:0] expReads[5];

    initial begin
        clearLogs();
        tick(); tick();
        rst = 1'b0;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_addr", {16'd0, addrOut}, 32'd0);

        // IRQ push/vector trace
        startReq(1'b0, 1'b1, 1'b0, 16'h1234, 8'hF3, 8'hFD);
        for (int k = 0; k < 8; k++) tick();
        check("irq_writes", writeLog.size(), 32'd3);
        if (writeLog.size() == 3) begin
            check("irq_w0", {8'd0, writeLog[0]}, {8'd0, 24'h01FD12});
            check("irq_w1", {8'd0, writeLog[1]}, {8'd0, 24'h01FC34});
            check("irq_w2", {8'd0, writeLog[2]}, {8'd0, 24'h01FBE3});
        end
        check("irq_pc", {16'd0, pcLog}, {16'd0, 16'h8000});
        check("irq_sp", {24'd0, spLog}, {24'd0, 8'hFA});
        check("irq_starts", startCount, 32'd1);

        // NMI wins over IRQ
        startReq(1'b1, 1'b1, 1'b0, 16'hBEEF, 8'h00, 8'h80);
        for (int k = 0; k < 8; k++) tick();
        check("nmi_reads", readLog.size(), 32'd2);
        if (readLog.size() == 2) begin
            check("nmi_r0", {16'd0, readLog[0]}, {16'd0, 16'hFFFA});
            check("nmi_r1", {16'd0, readLog[1]}, {16'd0, 16'hFFFB});
        end
        check("nmi_starts", startCount, 32'd1);

        // reset sequence: dummy reads, SP wraps
        startReq(1'b1, 1'b1, 1'b1, 16'h4321, 8'hFF, 8'h00);
        for (int k = 0; k < 8; k++) tick();
        check("rst_writes", writeLog.size(), 32'd0);
        expReads = '{16'h0100, 16'h01FF, 16'h01FE, 16'hFFFC, 16'hFFFD};
        check("rst_reads", readLog.size(), 32'd5);
        if (readLog.size() == 5)
            for (int k = 0; k < 5; k++) check("rst_read_addr", {16'd0, readLog[k]}, {16'd0, expReads[k]});
        check("rst_sp", {24'd0, spLog}, {24'd0, 8'hFD});

        // half-rate enable: each phase held for two clocks
        startReq(1'b0, 1'b1, 1'b0, 16'h1234, 8'hF3, 8'hFD);
        for (int k = 0; k < 24; k++) begin
            enableFFs = (k % 2 == 0) ? 1'b0 : 1'b1;
            tick();
        end
        enableFFs = 1'b1;
        check("toggle_busy_clocks", busyCount, 32'd12);
        check("toggle_writes", writeLog.size(), 32'd6);
        if (writeLog.size() == 6) begin
            check("toggle_w0", {8'd0, writeLog[0]}, {8'd0, 24'h01FD12});
            check("toggle_w5", {8'd0, writeLog[5]}, {8'd0, 24'h01FBE3});
        end
        check("toggle_pc", {16'd0, pcLog}, {16'd0, 16'h8000});

        // abort in PUSH_PCL
        startReq(1'b0, 1'b1, 1'b0, 16'h1234, 8'hF3, 8'hFD);
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_we", {31'd0, writeEn}, 32'd0);
        for (int k = 0; k < 8; k++) tick();
        check("abort_pcload", pcLoadCount, 32'd0);
        check("abort_writes", writeLog.size(), 32'd2);

        // pending request off an instruction boundary is ignored
        clearLogs();
        pendingInterrupt = 1'b1; irqGenerated = 1'b1; nmiGenerated = 1'b1;
        instructionBoundary = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        check("noboundary_busy", busyCount, 32'd0);
        check("noboundary_bus", writeLog.size() + readLog.size(), 32'd0);

        // pending with no qualifier stays idle
        clearLogs();
        instructionBoundary = 1'b1; irqGenerated = 1'b0; nmiGenerated = 1'b0; resetDetected = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        check("noqual_busy", busyCount, 32'd0);

        // randomized traffic
        for (int k = 0; k < 4000; k++) begin
            rst = ($urandom_range(199) == 0);
            enableFFs = ($urandom_range(3) != 0);
            pendingInterrupt = 1'($urandom_range(1));
            instructionBoundary = 1'($urandom_range(1));
            nmiGenerated = ($urandom_range(3) == 0);
            irqGenerated = ($urandom_range(2) == 0);
            resetDetected = ($urandom_range(5) == 0);
            pcIn = 16'($urandom); statusIn = 8'($urandom); spIn = 8'($urandom);
            memSeed = 8'($urandom);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
